axis_axi_burst_writer: RTL and testbench



---
 rtl/axis_axi_burst_writer_if.sv | 72 +++++++
 rtl/axis_axi_burst_writer.sv | 177 +++++++++++++++++
 tb/tb_axis_axi_burst_writer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_axi_burst_writer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi_burst_writer_if                                             |
// | Stream input, base-address load and AXI4 write channels for the      |
// | burst writer.                                                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface axis_axi_burst_writer_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 34
);
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic [KEEP_WIDTH-1:0] s_axis_tkeep;
  logic                  s_axis_tlast;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  logic [ADDR_WIDTH-1:0] axi_base_addr;
  logic                  axi_base_addr_valid;

  logic [5:0]            m_axi_awid;
  logic [ADDR_WIDTH-1:0] m_axi_awaddr;
  logic [7:0]            m_axi_awlen;
  logic [2:0]            m_axi_awsize;
  logic [1:0]            m_axi_awburst;
  logic                  m_axi_awlock;
  logic [3:0]            m_axi_awcache;
  logic [2:0]            m_axi_awprot;
  logic                  m_axi_awvalid;
  logic                  m_axi_awready;

  logic [DATA_WIDTH-1:0] m_axi_wdata;
  logic [KEEP_WIDTH-1:0] m_axi_wstrb;
  logic                  m_axi_wlast;
  logic                  m_axi_wvalid;
  logic                  m_axi_wready;

  logic [5:0]            m_axi_bid;
  logic [1:0]            m_axi_bresp;
  logic                  m_axi_bvalid;
  logic                  m_axi_bready;

  // Writer side: consumes the stream and masters the AXI write channels.
  modport master (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    input  axi_base_addr, axi_base_addr_valid,
    output m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bid, m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  // Environment side: stream source, address source and memory slave.
  modport slave (
    output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    output axi_base_addr, axi_base_addr_valid,
    input  m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bid, m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );
endinterface
`default_nettype wire

// File: rtl/axis_axi_burst_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_axi_burst_writer                                                |
// | Packs stream beats into 4 KB-safe AXI4 INCR write bursts, one burst  |
// | outstanding, counting OKAY bytes and flagging error responses.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module axis_axi_burst_writer #(
  parameter int DATA_WIDTH    = 512,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH    = 34,
  parameter int MAX_BURST_LEN = 16,
  parameter int AXI_ID        = 0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  axis_axi_burst_writer_if.master bus,
  output logic                    busy,
  output logic [31:0]             bytes_written,
  output logic                    resp_err
);
  localparam int c_LSB        = $clog2(KEEP_WIDTH);
  localparam int c_IDXW       = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;
  localparam int c_PAGE_BEATS = 4096 / KEEP_WIDTH;
  localparam int c_BUFW       = DATA_WIDTH + KEEP_WIDTH;

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_FILL = 3'd1;
  localparam logic [2:0] c_AW   = 3'd2;
  localparam logic [2:0] c_W    = 3'd3;
  localparam logic [2:0] c_B    = 3'd4;

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_pend;
  logic [ADDR_WIDTH-1:0] r_pend_addr;
  logic [8:0]            r_count;
  logic [8:0]            r_beats;
  logic [8:0]            r_widx;
  logic [31:0]           r_burst_bytes;
  logic [31:0]           r_bytes_written;
  logic                  r_resp_err;
  logic [c_BUFW-1:0]     r_buf [MAX_BURST_LEN];

  logic                  w_apply_fill;
  logic [11-c_LSB:0]     w_page_off;
  logic [12:0]           w_room;
  logic [8:0]            w_limit;
  logic                  w_accept;
  logic                  w_close;
  logic [31:0]           w_keep_cnt;
  logic [c_BUFW-1:0]     w_rd;
  logic                  w_wlast;
  logic [ADDR_WIDTH-1:0] w_step;
  logic [ADDR_WIDTH-1:0] w_base_masked;
  logic                  w_unused;

  // A pending base address taken at the start of FILL must also set this burst's limit.
  assign w_apply_fill = (r_state == c_FILL) && (r_count == 9'd0) && r_pend;
  assign w_page_off   = w_apply_fill ? r_pend_addr[11:c_LSB] : r_ptr[11:c_LSB];
  assign w_room       = 13'(c_PAGE_BEATS) - {{(13-(12-c_LSB)){1'b0}}, w_page_off};
  assign w_limit      = (w_room < 13'(MAX_BURST_LEN)) ? w_room[8:0] : 9'(MAX_BURST_LEN);

  assign w_accept = bus.s_axis_tvalid && (r_state == c_FILL);
  assign w_close  = w_accept && (((r_count + 9'd1) == w_limit) || bus.s_axis_tlast);

  always_comb begin
    w_keep_cnt = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_keep_cnt = w_keep_cnt + {31'd0, bus.s_axis_tkeep[i]};
    end
  end

  assign w_rd          = r_buf[r_widx[c_IDXW-1:0]];
  assign w_wlast       = (r_widx == (r_beats - 9'd1));
  assign w_step        = {{(ADDR_WIDTH-9){1'b0}}, r_beats} << c_LSB;
  assign w_base_masked = {bus.axi_base_addr[ADDR_WIDTH-1:c_LSB], {c_LSB{1'b0}}};
  assign w_unused      = ^{bus.m_axi_bid, bus.axi_base_addr[c_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_count[c_IDXW-1:0]] <= {bus.s_axis_tdata, bus.s_axis_tkeep};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= c_IDLE;
      r_ptr           <= '0;
      r_pend          <= 1'b0;
      r_pend_addr     <= '0;
      r_count         <= '0;
      r_beats         <= '0;
      r_widx          <= '0;
      r_burst_bytes   <= '0;
      r_bytes_written <= '0;
      r_resp_err      <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (r_pend) begin
            r_ptr  <= r_pend_addr;
            r_pend <= 1'b0;
          end else begin
            r_state <= c_FILL;
          end
        end
        c_FILL: begin
          if (w_apply_fill) begin
            r_ptr  <= r_pend_addr;
            r_pend <= 1'b0;
          end
          if (w_accept) begin
            r_count       <= r_count + 9'd1;
            r_burst_bytes <= r_burst_bytes + w_keep_cnt;
            if (w_close) begin
              r_beats <= r_count + 9'd1;
              r_state <= c_AW;
            end
          end
        end
        c_AW: begin
          if (bus.m_axi_awready) begin
            r_widx  <= '0;
            r_state <= c_W;
          end
        end
        c_W: begin
          if (bus.m_axi_wready) begin
            r_widx <= r_widx + 9'd1;
            if (w_wlast) r_state <= c_B;
          end
        end
        c_B: begin
          if (bus.m_axi_bvalid) begin
            if (bus.m_axi_bresp == 2'b00) r_bytes_written <= r_bytes_written + r_burst_bytes;
            else                          r_resp_err      <= 1'b1;
            r_ptr         <= r_ptr + w_step;
            r_count       <= '0;
            r_burst_bytes <= '0;
            r_state       <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
      // Placed after the FSM so a pulse in the B-handshake cycle survives the increment.
      if (bus.axi_base_addr_valid) begin
        r_pend      <= 1'b1;
        r_pend_addr <= w_base_masked;
      end
    end
  end

  assign bus.s_axis_tready = (r_state == c_FILL);

  assign bus.m_axi_awid    = 6'(AXI_ID);
  assign bus.m_axi_awaddr  = r_ptr;
  assign bus.m_axi_awlen   = 8'(r_beats - 9'd1);
  assign bus.m_axi_awsize  = 3'(c_LSB);
  assign bus.m_axi_awburst = 2'b01;
  assign bus.m_axi_awlock  = 1'b0;
  assign bus.m_axi_awcache = 4'b0011;
  assign bus.m_axi_awprot  = 3'b000;
  assign bus.m_axi_awvalid = (r_state == c_AW);

  assign bus.m_axi_wdata   = w_rd[c_BUFW-1:KEEP_WIDTH];
  assign bus.m_axi_wstrb   = w_rd[KEEP_WIDTH-1:0];
  assign bus.m_axi_wlast   = w_wlast;
  assign bus.m_axi_wvalid  = (r_state == c_W);

  assign bus.m_axi_bready  = (r_state == c_B);

  assign busy          = (r_state != c_IDLE);
  assign bytes_written = r_bytes_written;
  assign resp_err      = r_resp_err;
endmodule
`default_nettype wire

// File: tb/tb_axis_axi_burst_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_axi_burst_writer                                             |
// | Directed bench: stream source and AXI slave with hand-computed       |
// | burst addresses, lengths, strobes and byte counts.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_axis_axi_burst_writer;
  localparam int DW     = 512;
  localparam int KW     = 64;
  localparam int AW     = 34;
  localparam int BUDGET = 400;
  localparam logic [63:0] c_FULL = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] bytes_written;
  logic        resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int tag_next = 1;
  int outstanding = 0;
  int max_out = 0;
  logic [AW-1:0] exp_addr [8];
  logic [7:0]    exp_len  [8];
  logic [31:0]   b0;

  axis_axi_burst_writer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

  axis_axi_burst_writer #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ADDR_WIDTH(AW), .MAX_BURST_LEN(16), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy),
    .bytes_written(bytes_written), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) outstanding <= 0;
    else outstanding <= outstanding
                      + ((bus.m_axi_awvalid && bus.m_axi_awready) ? 1 : 0)
                      - ((bus.m_axi_bvalid && bus.m_axi_bready) ? 1 : 0);
  end
  always @(negedge clk) if (outstanding > max_out) max_out = outstanding;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_base(input logic [AW-1:0] addr);
    @(negedge clk);
    bus.axi_base_addr       = addr;
    bus.axi_base_addr_valid = 1'b1;
    @(negedge clk);
    bus.axi_base_addr_valid = 1'b0;
  endtask

  task automatic src(input int n, input int tag0, input logic [63:0] last_keep);
    int i;
    int cyc;
    i = 0; cyc = 0;
    while (i < n && cyc < BUDGET) begin
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = {16{32'(tag0 + i)}};
      bus.s_axis_tkeep  = (i == n - 1) ? last_keep : c_FULL;
      bus.s_axis_tlast  = (i == n - 1);
      if (bus.s_axis_tready) i++;
      @(negedge clk); cyc++;
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    chk("src_beats", 64'(i), 64'(n));
  endtask

  task automatic slv(input int nb, input int tag0, input int nbeats,
                     input logic [63:0] last_keep, input logic [1:0] first_bresp);
    int g;
    int j;
    int cyc;
    g = tag0;
    for (int k = 0; k < nb; k++) begin
      cyc = 0;
      while (!bus.m_axi_awvalid && cyc < BUDGET) begin @(negedge clk); cyc++; end
      chk($sformatf("aw%0d_valid", k), 64'(bus.m_axi_awvalid), 64'd1);
      @(negedge clk);
      chk($sformatf("aw%0d_hold", k), 64'(bus.m_axi_awvalid), 64'd1);
      chk($sformatf("aw%0d_addr", k), 64'(bus.m_axi_awaddr), 64'(exp_addr[k]));
      chk($sformatf("aw%0d_len", k), 64'(bus.m_axi_awlen), 64'(exp_len[k]));
      bus.m_axi_awready = 1'b1;
      @(negedge clk);
      bus.m_axi_awready = 1'b0;
      j = 0; cyc = 0;
      while (j <= int'(exp_len[k]) && cyc < BUDGET) begin
        bus.m_axi_wready = (cyc % 3 != 1);
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          chk($sformatf("w%0d_%0d_data", k, j), 64'(bus.m_axi_wdata[31:0]), 64'(g));
          chk($sformatf("w%0d_%0d_last", k, j), 64'(bus.m_axi_wlast), 64'(j == int'(exp_len[k])));
          chk($sformatf("w%0d_%0d_strb", k, j), bus.m_axi_wstrb,
              (g == tag0 + nbeats - 1) ? last_keep : c_FULL);
          j++; g++;
        end
        @(negedge clk); cyc++;
      end
      bus.m_axi_wready = 1'b0;
      chk($sformatf("w%0d_count", k), 64'(j), 64'(exp_len[k]) + 64'd1);
      cyc = 0;
      while (!bus.m_axi_bready && cyc < BUDGET) begin @(negedge clk); cyc++; end
      chk($sformatf("b%0d_ready", k), 64'(bus.m_axi_bready), 64'd1);
      bus.m_axi_bvalid = 1'b1;
      bus.m_axi_bresp  = (k == 0) ? first_bresp : 2'b00;
      @(negedge clk);
      bus.m_axi_bvalid = 1'b0;
      bus.m_axi_bresp  = 2'b00;
    end
  endtask

  task automatic run(input int n, input logic [63:0] last_keep, input int nb,
                     input logic [1:0] first_bresp);
    int t0;
    t0 = tag_next;
    tag_next += n;
    fork
      src(n, t0, last_keep);
      slv(nb, t0, n, last_keep, first_bresp);
    join
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_tready"}, 64'(bus.s_axis_tready), 64'd0);
    chk({pfx, "_awvalid"}, 64'(bus.m_axi_awvalid), 64'd0);
    chk({pfx, "_wvalid"}, 64'(bus.m_axi_wvalid), 64'd0);
    chk({pfx, "_bready"}, 64'(bus.m_axi_bready), 64'd0);
    chk({pfx, "_busy"}, 64'(busy), 64'd0);
    chk({pfx, "_bytes"}, 64'(bytes_written), 64'd0);
    chk({pfx, "_err"}, 64'(resp_err), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int j;
    int cyc;
    int t0;
    bus.s_axis_tdata = '0; bus.s_axis_tkeep = '0; bus.s_axis_tlast = 1'b0;
    bus.s_axis_tvalid = 1'b0; bus.axi_base_addr = '0; bus.axi_base_addr_valid = 1'b0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bid = 6'd0;
    bus.m_axi_bresp = 2'b00; bus.m_axi_bvalid = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("awsize", 64'(bus.m_axi_awsize), 64'd6);
    chk("awburst", 64'(bus.m_axi_awburst), 64'd1);
    chk("awcache", 64'(bus.m_axi_awcache), 64'd3);
    chk("awid", 64'(bus.m_axi_awid), 64'd0);
    rst = 1'b0;

    // 3-beat frame at 0x1000
    set_base(34'h1000);
    exp_addr[0] = 34'h1000; exp_len[0] = 8'd2;
    run(3, c_FULL, 1, 2'b00);
    chk("t1_bytes", 64'(bytes_written), 64'd192);

    // partial-keep single beat continues at the advanced pointer
    exp_addr[0] = 34'h10C0; exp_len[0] = 8'd0;
    run(1, 64'h0000_0000_0000_FFFF, 1, 2'b00);
    chk("t4_bytes", 64'(bytes_written), 64'd208);

    // 40 beats split at MAX_BURST_LEN
    set_base(34'h0);
    b0 = bytes_written;
    exp_addr[0] = 34'h000; exp_len[0] = 8'd15;
    exp_addr[1] = 34'h400; exp_len[1] = 8'd15;
    exp_addr[2] = 34'h800; exp_len[2] = 8'd7;
    run(40, c_FULL, 3, 2'b00);
    chk("t2_bytes", 64'(bytes_written - b0), 64'd2560);
    chk("t2_outstanding", 64'(max_out), 64'd1);

    // 4 KB boundary split
    set_base(34'hF80);
    b0 = bytes_written;
    exp_addr[0] = 34'hF80;  exp_len[0] = 8'd1;
    exp_addr[1] = 34'h1000; exp_len[1] = 8'd13;
    run(16, c_FULL, 2, 2'b00);
    chk("t3_bytes", 64'(bytes_written - b0), 64'd1024);

    // SLVERR response
    set_base(34'h2000);
    b0 = bytes_written;
    exp_addr[0] = 34'h2000; exp_len[0] = 8'd3;
    run(4, c_FULL, 1, 2'b10);
    chk("t5_err", 64'(resp_err), 64'd1);
    chk("t5_bytes", 64'(bytes_written), 64'(b0));
    exp_addr[0] = 34'h2100; exp_len[0] = 8'd0;
    run(1, c_FULL, 1, 2'b00);
    chk("t5_err_sticky", 64'(resp_err), 64'd1);
    chk("t5_bytes2", 64'(bytes_written - b0), 64'd64);

    // reset while W is at beat 2 of 5
    set_base(34'h3000);
    t0 = tag_next;
    tag_next += 5;
    src(5, t0, c_FULL);
    cyc = 0;
    while (!bus.m_axi_awvalid && cyc < BUDGET) begin @(negedge clk); cyc++; end
    chk("t6_aw_addr", 64'(bus.m_axi_awaddr), 64'h3000);
    chk("t6_aw_len", 64'(bus.m_axi_awlen), 64'd4);
    bus.m_axi_awready = 1'b1;
    @(negedge clk);
    bus.m_axi_awready = 1'b0;
    bus.m_axi_wready  = 1'b1;
    j = 0; cyc = 0;
    while (j < 2 && cyc < BUDGET) begin
      if (bus.m_axi_wvalid) begin
        chk($sformatf("t6_w%0d_data", j), 64'(bus.m_axi_wdata[31:0]), 64'(t0 + j));
        chk($sformatf("t6_w%0d_last", j), 64'(bus.m_axi_wlast), 64'd0);
        j++;
      end
      @(negedge clk); cyc++;
    end
    chk("t6_w_mid", 64'(bus.m_axi_wvalid), 64'd1);
    bus.m_axi_wready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("t6_rst");
    rst = 1'b0;
    exp_addr[0] = 34'h0; exp_len[0] = 8'd0;
    run(1, c_FULL, 1, 2'b00);
    chk("t6_bytes_a", 64'(bytes_written), 64'd64);
    set_base(34'h5000);
    exp_addr[0] = 34'h5000; exp_len[0] = 8'd1;
    run(2, c_FULL, 1, 2'b00);
    chk("t6_bytes_b", 64'(bytes_written), 64'd192);
    chk("t6_err", 64'(resp_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
